demux_8ch_deserializer: RTL and testbench
=========================================

Name: demux_8ch_deserializer

Overview:
- Sits directly downstream of the 1-to-8 demultiplexer and consumes its 8-bit dout bus and the 3-bit select.
- Each bit strobed on the selected output line is shifted into a per-channel shift register.
- Each full WORD_W-bit word is buffered in a per-channel holding register.
- Holding registers are drained through a single round-robin-arbitrated valid/ready output port tagged with the channel number.

Parameters:
WORD_W, 8, bits per assembled word; legal range 2..32.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
bit_valid  input  1  qualifies sel/dout this cycle; needed because din=0 produces an all-zero dout.
sel  input  3  channel index driving the demux.
dout  input  8  demux outputs; only dout[sel] is sampled, the other bits are ignored.
word_valid  output  1  output word available.
word_ready  input  1  consumer accepts the word when word_valid&&word_ready.
word_data  output  WORD_W  assembled word, first-received bit at MSB.
word_ch  output  3  channel that produced word_data.
pending  output  8  per-channel holding-register-full flags.
overflow  output  8  sticky per-channel word-dropped flags.
clr_overflow  input  8  per-bit clear of overflow.

Behaviour:
- Reset (synchronous, rst=1 at an edge) clears:
  - all shift registers, bit counters and holding registers;
  - pending=0, overflow=0, word_valid=0, word_data=0, word_ch=0;
  - round-robin pointer to 0.
- Reset mid-word discards partial bits and any buffered or presented words.
- Sampling, on an edge with bit_valid=1 and c=sel:
  - b=dout[c];
  - shreg[c] <= {shreg[c][WORD_W-2:0], b};
  - cnt[c] <= cnt[c]+1;
  - other channels are untouched.
- Completion: when bit_valid=1 and cnt[c]==WORD_W-1, the word {shreg[c][WORD_W-2:0], b} completes and cnt[c] <= 0.
  - If pending[c]=0, or hold[c] is popped by the arbiter this same edge: hold[c] <= word and pending[c] <= 1.
  - Otherwise the new word is dropped, hold[c] is unchanged and overflow[c] <= 1.
- Output stage is a single register (word_valid/word_data/word_ch).
  - It loads when (!word_valid || word_ready) and pending!=0.
  - Grant goes to the first pending channel scanning rr_ptr, rr_ptr+1, ... mod 8.
  - On grant k: output <= hold[k], word_ch <= k, pending[k] <= 0 (unless refilled the same edge), rr_ptr <= k+1 mod 8.
  - With no pending channel and the word accepted: word_valid <= 0.
- Latency: a word completing at edge N sets pending at N and can appear on word_valid after edge N+1. There is no bypass path.
- Back-to-back: with word_ready held 1, one word per cycle is sustained.
- Stability: word_data/word_ch are held stable while word_valid && !word_ready.
- overflow[i] is sticky:
  - clr_overflow[i] clears it;
  - a set and a clear on the same edge: set wins.
- Total buffering per channel is 1 holding register, plus the shared output register.

Test Plan:
- Reset; word_ready=1; bit_valid=1 on 8 consecutive cycles with sel=3 and din bits 1,0,1,1,0,0,1,0.
  - Required: pending[3] rises at the 8th-bit edge.
  - Required: word_valid for 1 cycle one edge later, word_data=8'hB2, word_ch=3.
  - Required: pending returns to 0.
- Interleave: alternate sel=0 (din=1) and sel=7 (din=0) for 16 valid cycles; insert idle bit_valid=0 cycles.
  - Required: words ch0=8'hFF and ch7=8'h00, no crosstalk.
  - Required: idle cycles do not change any counter.
- Backpressure/arbitration: word_ready=0; complete words on ch5=8'h55, then ch1=8'h11, then ch2=8'h22, one cycle apart; raise word_ready.
  - Required output order: 8'h55/ch5 (already loaded), 8'h11/ch1, 8'h22/ch2 (pointer starts at 6, wraps).
  - Required: word_data stable while stalled.
- Overflow: word_ready=0; complete three words on ch4: 8'h01, 8'h02, 8'h03.
  - Required: overflow[4]=1 after the third word; 8'h03 is dropped.
  - Required on release: 8'h01 then 8'h02.
  - Required: a clr_overflow[4] pulse clears the flag; clr coinciding with a new overflow leaves it set.
- Reset mid-word: 5 bits to ch6; rst for 1 cycle; then 8 bits of 8'hA5 to ch6.
  - Required: a single word 8'hA5/ch6 with no stale bits.
  - Required: rst while word_valid=1 drops word_valid next cycle.
- Simultaneous pop and complete: ch2 pending, a new ch2 word completes on the same edge as the ch2 grant.
  - Required: old word presented, new word held, pending[2] stays 1, no overflow.

Source files
------------

// File: rtl/demux_8ch_deserializer_if.sv
// Bit-side and word-side signals of the 8-channel deserializer.
// The slave modport is the deserializer; the master modport is its environment.
interface demux_8ch_deserializer_if #(
  parameter int WORD_W = 8
);
  logic              bit_valid;
  logic [2:0]        sel;
  logic [7:0]        dout;
  logic              word_valid;
  logic              word_ready;
  logic [WORD_W-1:0] word_data;
  logic [2:0]        word_ch;
  logic [7:0]        pending;
  logic [7:0]        overflow;
  logic [7:0]        clr_overflow;

  modport slave (
    input  bit_valid, sel, dout, word_ready, clr_overflow,
    output word_valid, word_data, word_ch, pending, overflow
  );

  modport master (
    output bit_valid, sel, dout, word_ready, clr_overflow,
    input  word_valid, word_data, word_ch, pending, overflow
  );
endinterface

// File: rtl/demux_8ch_deserializer.sv
// Per-channel serial-to-parallel assembly behind a 1:8 demux, with one holding
// register per channel and a round-robin drained, channel-tagged output register.

module demux_8ch_lane #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              samp,
  input  logic              b,
  input  logic              pop,
  input  logic              clr,
  output logic [WORD_W-1:0] hold,
  output logic              pending,
  output logic              overflow
);
  localparam int CW = (WORD_W > 2) ? $clog2(WORD_W) : 1;

  logic [WORD_W-2:0] shreg;
  logic [CW-1:0]     cnt;
  logic [WORD_W-1:0] word;
  logic              complete;
  logic              accept;

  assign word     = {shreg, b};
  assign complete = samp && (cnt == CW'(WORD_W - 1));
  // A pop on the same edge frees the holding register for the new word.
  assign accept   = complete && (!pending || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (samp) begin
      shreg <= word[WORD_W-2:0];
      cnt   <= complete ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold    <= '0;
      pending <= 1'b0;
    end else if (accept) begin
      hold    <= word;
      pending <= 1'b1;
    end else if (pop) begin
      pending <= 1'b0;
    end
  end

  // Set has priority over a coincident clear.
  always_ff @(posedge clk) begin
    if (rst)
      overflow <= 1'b0;
    else if (complete && !accept)
      overflow <= 1'b1;
    else if (clr)
      overflow <= 1'b0;
  end
endmodule

module demux_8ch_deserializer #(
  parameter int WORD_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  demux_8ch_deserializer_if.slave bus
);
  localparam int NUM_LANES = 8;

  logic [NUM_LANES-1:0][WORD_W-1:0] hold;
  logic [NUM_LANES-1:0]             pending;
  logic [NUM_LANES-1:0]             overflow;
  logic [NUM_LANES-1:0]             pop;
  logic                             b;

  logic [2:0]        rr_ptr;
  logic [2:0]        gnt_idx;
  logic [2:0]        cand;
  logic              gnt_found;
  logic              load;
  logic              word_valid;
  logic [WORD_W-1:0] word_data;
  logic [2:0]        word_ch;

  // Only the selected demux line carries the bit; the rest are don't-care.
  assign b = bus.dout[bus.sel];

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    demux_8ch_lane #(.WORD_W(WORD_W)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .samp     (bus.bit_valid && (bus.sel == 3'(i))),
      .b        (b),
      .pop      (pop[i]),
      .clr      (bus.clr_overflow[i]),
      .hold     (hold[i]),
      .pending  (pending[i]),
      .overflow (overflow[i])
    );
  end

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = rr_ptr;
    cand      = '0;
    for (int j = 0; j < NUM_LANES; j++) begin
      cand = rr_ptr + 3'(j);
      if (!gnt_found && pending[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign load = (!word_valid || bus.word_ready) && gnt_found;

  always_comb begin
    pop = '0;
    if (load) pop[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_valid <= 1'b0;
      word_data  <= '0;
      word_ch    <= '0;
      rr_ptr     <= '0;
    end else if (load) begin
      word_valid <= 1'b1;
      word_data  <= hold[gnt_idx];
      word_ch    <= gnt_idx;
      rr_ptr     <= gnt_idx + 3'd1;
    end else if (bus.word_ready) begin
      word_valid <= 1'b0;
    end
  end

  assign bus.word_valid = word_valid;
  assign bus.word_data  = word_data;
  assign bus.word_ch    = word_ch;
  assign bus.pending    = pending;
  assign bus.overflow   = overflow;
endmodule

// File: tb/tb_demux_8ch_deserializer.sv
// Scenario-driven bench: expected words are queued as stimulus completes them
// and popped by a handshake monitor as the output port delivers them.
module tb_demux_8ch_deserializer;
  localparam int WORD_W = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [WORD_W+2:0] exp_q[$];

  demux_8ch_deserializer_if #(.WORD_W(WORD_W)) bus ();

  demux_8ch_deserializer #(.WORD_W(WORD_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake monitor: inputs change #1 after posedge, so negedge sees what the next edge sees.
  always @(negedge clk) begin
    logic [WORD_W+2:0] e;
    if (!rst && bus.word_valid === 1'b1 && bus.word_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got ch%0d data %h, queue empty", bus.word_ch, bus.word_data);
      end else begin
        e = exp_q.pop_front();
        if ({bus.word_ch, bus.word_data} !== e) begin
          errors++;
          $display("FAIL word_order: got ch%0d data %h, expected ch%0d data %h",
                   bus.word_ch, bus.word_data, e[WORD_W+2:WORD_W], e[WORD_W-1:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic [2:0] c, input logic bv);
    logic [7:0] d;
    d = 8'($urandom);
    d[c] = bv;
    bus.bit_valid = 1'b1;
    bus.sel       = c;
    bus.dout      = d;
    tick();
    bus.bit_valid = 1'b0;
    bus.dout      = 8'($urandom);
  endtask

  task automatic send_bits(input logic [2:0] c, input logic [WORD_W-1:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) send_bit(c, w[i]);
  endtask

  task automatic push(input logic [2:0] c, input logic [WORD_W-1:0] w);
    exp_q.push_back({c, w});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.word_valid !== 1'b0) && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL drain_timeout: %0d words outstanding, word_valid %b", exp_q.size(), bus.word_valid);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (bus.word_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", bus.word_valid); end
    checks++;
    if (bus.pending !== 8'h00) begin errors++; $display("FAIL reset_pending: got %h, expected 00", bus.pending); end
    checks++;
    if (bus.overflow !== 8'h00) begin errors++; $display("FAIL reset_overflow: got %h, expected 00", bus.overflow); end
    checks++;
    if (bus.word_data !== '0 || bus.word_ch !== 3'd0) begin
      errors++; $display("FAIL reset_outreg: got ch%0d data %h, expected ch0 data 00", bus.word_ch, bus.word_data);
    end
  endtask

  task automatic test_basic();
    bus.word_ready = 1'b1;
    send_bits(3'd3, 8'hB2, 7, 1);
    checks++;
    if (bus.pending !== 8'h00) begin errors++; $display("FAIL basic_early_pending: got %h, expected 00", bus.pending); end
    push(3'd3, 8'hB2);
    send_bit(3'd3, 1'b0);
    checks++;
    if (bus.pending !== 8'h08 || bus.word_valid !== 1'b0) begin
      errors++; $display("FAIL basic_pending: got pending %h valid %b, expected 08 and 0", bus.pending, bus.word_valid);
    end
    tick();
    checks++;
    if (bus.word_valid !== 1'b1 || bus.word_data !== 8'hB2 || bus.word_ch !== 3'd3) begin
      errors++; $display("FAIL basic_out: got v%b ch%0d %h, expected v1 ch3 b2", bus.word_valid, bus.word_ch, bus.word_data);
    end
    checks++;
    if (bus.pending !== 8'h00) begin errors++; $display("FAIL basic_pending_clear: got %h, expected 00", bus.pending); end
    tick();
    checks++;
    if (bus.word_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle: got %b, expected 0", bus.word_valid); end
    drain();
  endtask

  task automatic test_interleave();
    bus.word_ready = 1'b1;
    for (int i = 0; i < WORD_W; i++) begin
      if (i == WORD_W - 1) push(3'd0, 8'hFF);
      send_bit(3'd0, 1'b1);
      if (i == 3) begin
        repeat (3) tick();
        checks++;
        if (bus.pending !== 8'h00 || bus.word_valid !== 1'b0) begin
          errors++; $display("FAIL idle_state: got pending %h valid %b, expected 00 and 0", bus.pending, bus.word_valid);
        end
      end
      if (i == WORD_W - 1) push(3'd7, 8'h00);
      send_bit(3'd7, 1'b0);
    end
    drain();
  endtask

  task automatic test_backpressure();
    bus.word_ready = 1'b0;
    send_bits(3'd5, 8'h55, 7, 1);
    send_bits(3'd1, 8'h11, 7, 1);
    send_bits(3'd2, 8'h22, 7, 1);
    push(3'd5, 8'h55);
    send_bit(3'd5, 1'b1);
    push(3'd1, 8'h11);
    send_bit(3'd1, 1'b1);
    push(3'd2, 8'h22);
    send_bit(3'd2, 1'b0);
    checks++;
    if (bus.pending !== 8'h06) begin errors++; $display("FAIL bp_pending: got %h, expected 06", bus.pending); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.word_valid !== 1'b1 || bus.word_data !== 8'h55 || bus.word_ch !== 3'd5) begin
        errors++; $display("FAIL bp_stable: cycle %0d got v%b ch%0d %h, expected v1 ch5 55", k, bus.word_valid, bus.word_ch, bus.word_data);
      end
      tick();
    end
    bus.word_ready = 1'b1;
    drain();
  endtask

  task automatic test_overflow();
    bus.word_ready = 1'b0;
    push(3'd4, 8'h01);
    send_bits(3'd4, 8'h01, 7, 0);
    push(3'd4, 8'h02);
    send_bits(3'd4, 8'h02, 7, 0);
    checks++;
    if (bus.overflow !== 8'h00) begin errors++; $display("FAIL ovf_early: got %h, expected 00", bus.overflow); end
    send_bits(3'd4, 8'h03, 7, 0);
    checks++;
    if (bus.overflow !== 8'h10 || bus.pending !== 8'h10) begin
      errors++; $display("FAIL ovf_set: got ovf %h pending %h, expected 10 and 10", bus.overflow, bus.pending);
    end
    bus.word_ready = 1'b1;
    drain();
    checks++;
    if (bus.overflow !== 8'h10) begin errors++; $display("FAIL ovf_sticky: got %h, expected 10", bus.overflow); end
    bus.clr_overflow = 8'h10;
    tick();
    bus.clr_overflow = 8'h00;
    checks++;
    if (bus.overflow !== 8'h00) begin errors++; $display("FAIL ovf_clear: got %h, expected 00", bus.overflow); end
    bus.word_ready = 1'b0;
    push(3'd4, 8'h04);
    send_bits(3'd4, 8'h04, 7, 0);
    push(3'd4, 8'h05);
    send_bits(3'd4, 8'h05, 7, 0);
    send_bits(3'd4, 8'h06, 7, 1);
    bus.clr_overflow = 8'h10;
    send_bit(3'd4, 1'b0);
    bus.clr_overflow = 8'h00;
    checks++;
    if (bus.overflow !== 8'h10) begin errors++; $display("FAIL ovf_set_wins: got %h, expected 10", bus.overflow); end
    bus.word_ready = 1'b1;
    drain();
    bus.clr_overflow = 8'h10;
    tick();
    bus.clr_overflow = 8'h00;
  endtask

  task automatic test_reset_mid();
    bus.word_ready = 1'b1;
    send_bits(3'd6, 8'hFF, 4, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push(3'd6, 8'hA5);
    send_bits(3'd6, 8'hA5, 7, 0);
    drain();
    bus.word_ready = 1'b0;
    send_bits(3'd6, 8'h3C, 7, 0);
    tick();
    checks++;
    if (bus.word_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid: got %b, expected 1", bus.word_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.word_valid !== 1'b0 || bus.pending !== 8'h00) begin
      errors++; $display("FAIL rst_drop: got valid %b pending %h, expected 0 and 00", bus.word_valid, bus.pending);
    end
  endtask

  task automatic test_pop_complete();
    bus.word_ready = 1'b0;
    push(3'd0, 8'hC3);
    send_bits(3'd0, 8'hC3, 7, 0);
    push(3'd2, 8'hA1);
    send_bits(3'd2, 8'hA1, 7, 0);
    checks++;
    if (bus.pending !== 8'h04) begin errors++; $display("FAIL pc_pending_pre: got %h, expected 04", bus.pending); end
    send_bits(3'd2, 8'h5E, 7, 1);
    push(3'd2, 8'h5E);
    bus.word_ready = 1'b1;
    send_bit(3'd2, 1'b0);
    checks++;
    if (bus.word_valid !== 1'b1 || bus.word_data !== 8'hA1 || bus.word_ch !== 3'd2) begin
      errors++; $display("FAIL pc_out: got v%b ch%0d %h, expected v1 ch2 a1", bus.word_valid, bus.word_ch, bus.word_data);
    end
    checks++;
    if (bus.pending !== 8'h04 || bus.overflow !== 8'h00) begin
      errors++; $display("FAIL pc_hold: got pending %h ovf %h, expected 04 and 00", bus.pending, bus.overflow);
    end
    drain();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.bit_valid    = 1'b0;
    bus.sel          = 3'd0;
    bus.dout         = 8'h00;
    bus.word_ready   = 1'b0;
    bus.clr_overflow = 8'h00;
    test_reset();
    test_basic();
    test_interleave();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_pop_complete();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL leftover: %0d words never delivered, expected 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
